// File: rtl/bin2bcd_disp_if.sv
// Handshake and result bundle between a conversion requester and bin2bcd_disp.
// Build option LEADING_ZERO_MASK_EN adds the digit_on leading-zero mask.
interface bin2bcd_disp_if #(
  parameter int BIN_W  = 27,
  parameter int DIGITS = 8
);
  logic                  start;
  logic [BIN_W-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic                  overflow;
  logic [4*DIGITS-1:0]   disp_data;
`ifdef LEADING_ZERO_MASK_EN
  logic [DIGITS-1:0]     digit_on;

  modport master (output start, bin_in,
                  input  busy, done, overflow, disp_data, digit_on);
  modport slave  (input  start, bin_in,
                  output busy, done, overflow, disp_data, digit_on);
`else
  modport master (output start, bin_in,
                  input  busy, done, overflow, disp_data);
  modport slave  (input  start, bin_in,
                  output busy, done, overflow, disp_data);
`endif
endinterface

// File: rtl/bin2bcd_disp.sv
// Sequential shift-and-add-3 binary to packed BCD converter for the 8-digit scan driver.
// Build option LEADING_ZERO_MASK_EN adds a registered leading-zero mask (digit_on).
module bin2bcd_disp #(
  parameter int BIN_W  = 27,
  parameter int DIGITS = 8
) (
  input  logic            Clk,
  input  logic            Rst,
  bin2bcd_disp_if.slave   bus
);

  localparam int DW = 4 * DIGITS;
  localparam int CW = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  function automatic logic [63:0] max_value();
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < DIGITS; i++) p = p * 64'd10;
    return p - 64'd1;
  endfunction

  localparam logic [63:0] MAX_VAL = max_value();

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

  state_t              state;
  logic [BIN_W-1:0]    shift_reg;
  logic [DW-1:0]       bcd;
  logic [CW-1:0]       cnt;
  logic                ovf_pending;
  logic                busy_r;
  logic                done_r;
  logic                overflow_r;
  logic [DW-1:0]       disp_r;
  logic [DW-1:0]       bcd_adj;
  logic [DW+BIN_W-1:0] shifted;
  logic [63:0]         bin_ext;

  assign bin_ext = 64'(bus.bin_in);

  // Add-3 correction on every digit that would exceed 9 after doubling.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  assign shifted = {bcd_adj, shift_reg} << 1;

`ifdef LEADING_ZERO_MASK_EN
  logic [DIGITS-1:0] mask_next;
  logic [DIGITS-1:0] mask_r;
  logic              any_hi;

  always_comb begin
    mask_next = '0;
    any_hi    = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      any_hi       = any_hi | (bcd[4*i +: 4] != 4'd0);
      mask_next[i] = any_hi;
    end
    mask_next[0] = 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      mask_r <= DIGITS'(1);
    end else if (state == FINISH) begin
      mask_r <= ovf_pending ? '1 : mask_next;
    end
  end

  assign bus.digit_on = mask_r;
`endif

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state       <= IDLE;
      shift_reg   <= '0;
      bcd         <= '0;
      cnt         <= '0;
      ovf_pending <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      overflow_r  <= 1'b0;
      disp_r      <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            shift_reg   <= bus.bin_in;
            bcd         <= '0;
            cnt         <= '0;
            ovf_pending <= (bin_ext > MAX_VAL);
            busy_r      <= 1'b1;
            state       <= SHIFT;
          end
        end
        SHIFT: begin
          bcd       <= shifted[DW+BIN_W-1:BIN_W];
          shift_reg <= shifted[BIN_W-1:0];
          cnt       <= cnt + CW'(1);
          if (cnt == CW'(BIN_W - 1)) state <= FINISH;
        end
        FINISH: begin
          disp_r     <= ovf_pending ? {DIGITS{4'h9}} : bcd;
          overflow_r <= ovf_pending;
          done_r     <= 1'b1;
          busy_r     <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.overflow  = overflow_r;
  assign bus.disp_data = disp_r;

endmodule

// File: tb/tb_bin2bcd_disp.sv
// Scoreboard bench for bin2bcd_disp: a decimal-arithmetic model predicts each result,
// a negedge monitor compares whenever done is presented.
module tb_bin2bcd_disp;

  localparam int BIN_W  = 27;
  localparam int DIGITS = 8;

  typedef struct {
    longint value;
    longint data;
    bit     ovf;
    longint mask;
    int     done_cycle;
  } exp_t;

  logic   Clk;
  logic   Rst;
  exp_t   sb[$];
  int     cycle      = 0;
  int     model_free = 0;
  int     checks     = 0;
  int     errors     = 0;
  longint held_data  = 0;
  bit     held_ovf   = 0;
  longint held_mask  = 1;

  bin2bcd_disp_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

  bin2bcd_disp #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic longint pow10(int n);
    longint p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  // Decimal reference: digits by division, saturating to all nines above the display range.
  function automatic exp_t model(longint v, int accept_cycle);
    exp_t e;
    e.value      = v;
    e.done_cycle = accept_cycle + BIN_W + 1;
    e.ovf        = (v > pow10(DIGITS) - 1);
    e.data       = 0;
    e.mask       = 0;
    for (int i = 0; i < DIGITS; i++) begin
      if (e.ovf) begin
        e.data = e.data | (longint'(9) << (4 * i));
        e.mask = e.mask | (longint'(1) << i);
      end else begin
        e.data = e.data | (((v / pow10(i)) % 10) << (4 * i));
        if (i == 0 || (v / pow10(i)) != 0) e.mask = e.mask | (longint'(1) << i);
      end
    end
    return e;
  endfunction

  task automatic checkOutput(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h required 0x%0h", name, cycle, act, req);
    end
  endtask

  // Acceptance model: a request is taken only when the converter is known to be idle.
  always @(posedge Clk) begin
    cycle = cycle + 1;
    if (Rst) begin
      sb.delete();
      model_free = cycle + 1;
      held_data  = 0;
      held_ovf   = 0;
      held_mask  = 1;
    end else if (bus.start === 1'b1 && cycle >= model_free) begin
      sb.push_back(model(longint'(bus.bin_in), cycle));
      model_free = cycle + BIN_W + 2;
    end
  end

  always @(negedge Clk) begin
    exp_t e;
    checkOutput("busy", longint'(bus.busy), longint'(cycle < model_free - 1));
    if (bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_done at cycle %0d: got done=1 required done=0", cycle);
      end else begin
        e = sb.pop_front();
        checkOutput("latency", longint'(cycle), longint'(e.done_cycle));
        checkOutput("disp_data", longint'(bus.disp_data), e.data);
        checkOutput("overflow", longint'(bus.overflow), longint'(e.ovf));
`ifdef LEADING_ZERO_MASK_EN
        checkOutput("digit_on", longint'(bus.digit_on), e.mask);
`endif
        held_data = e.data;
        held_ovf  = e.ovf;
        held_mask = e.mask;
      end
    end else begin
      checkOutput("held_data", longint'(bus.disp_data), held_data);
      checkOutput("held_ovf", longint'(bus.overflow), longint'(held_ovf));
`ifdef LEADING_ZERO_MASK_EN
      checkOutput("held_mask", longint'(bus.digit_on), held_mask);
`endif
      if (sb.size() > 0 && sb[0].done_cycle < cycle) begin
        e = sb.pop_front();
        checks++;
        errors++;
        $display("[TB] FAIL missing_done for value %0d: got no done by cycle %0d required at %0d",
                 e.value, cycle, e.done_cycle);
      end
    end
  end

  task automatic stepCycles(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic applyStimulus(input longint v);
    @(posedge Clk);
    #1;
    bus.start  = 1'b1;
    bus.bin_in = BIN_W'(v);
    @(posedge Clk);
    #1;
    bus.start  = 1'b0;
  endtask

  task automatic convertAndWait(input longint v);
    applyStimulus(v);
    stepCycles(BIN_W + 3);
  endtask

  initial begin
    longint v;
    int     gap;
    int     waited;

    Rst        = 1'b1;
    bus.start  = 1'b0;
    bus.bin_in = '0;
    stepCycles(2);
    Rst = 1'b0;

    // Abort a conversion in flight with a two-cycle reset.
    stepCycles(2);
    applyStimulus(12345678);
    stepCycles(6);
    Rst = 1'b1;
    stepCycles(2);
    Rst = 1'b0;
    stepCycles(3);

    $display("[TB] directed conversions");
    convertAndWait(12345678);
    convertAndWait(0);
    convertAndWait(99999999);
    convertAndWait(9);
    convertAndWait(100000000);
    convertAndWait(42);
    convertAndWait(134217727);
    convertAndWait(1);

    $display("[TB] start while busy");
    applyStimulus(1234);
    stepCycles(9);
    applyStimulus(5678);
    stepCycles(BIN_W + 3);

    $display("[TB] continuous start");
    @(posedge Clk);
    #1;
    bus.start  = 1'b1;
    bus.bin_in = BIN_W'(10);
    repeat (6 * (BIN_W + 2)) begin
      @(posedge Clk);
      #1;
      bus.bin_in = (bus.bin_in == BIN_W'(10)) ? BIN_W'(20) : BIN_W'(10);
    end
    bus.start = 1'b0;
    stepCycles(BIN_W + 3);

    $display("[TB] randomized conversions");
    repeat (40) begin
      case ($urandom_range(0, 4))
        0:       v = longint'($urandom_range(0, 99));
        1:       v = longint'($urandom_range(99999990, 100000010));
        default: v = longint'($urandom_range(0, 32'h7FFFFFF));
      endcase
      gap = $urandom_range(0, 35);
      applyStimulus(v);
      stepCycles(gap);
    end

    waited = 0;
    while (sb.size() != 0 && waited < 200) begin
      stepCycles(1);
      waited++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain_timeout: got %0d pending results required 0", sb.size());
    end
    stepCycles(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bin2bcd_disp.md
Name: bin2bcd_disp

Overview:
- Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
- Sits directly upstream of the 8-digit seven-segment scan driver and produces its 32-bit packed-nibble display word.
- Digit 0 is in bits [3:0] and digit 7 in bits [31:28], matching the driver's scan order.
- The output word is updated atomically on completion, so the display never shows intermediate values.

Parameters:
- BIN_W, 27, binary input width. Must be at least 1 and no more than 4*DIGITS.
- DIGITS, 8, number of BCD digits produced. disp_data width is 4*DIGITS.

Ports:
- Clk  input  1  system clock (50 MHz).
- Rst  input  1  synchronous reset, active-high.
- start  input  1  conversion request. Sampled only in IDLE.
- bin_in  input  BIN_W  unsigned value. Captured on the edge where start is accepted.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when disp_data has been updated.
- overflow  output  1  the last accepted value exceeded 10^DIGITS-1.
- disp_data  output  4*DIGITS  packed BCD result, held between conversions.

Behaviour:
- Reset: one clock, one reset. Reset is synchronous and active-high (Rst sampled on posedge Clk). While Rst=1, all of the following hold:
  - state = IDLE
  - busy = 0, done = 0, overflow = 0
  - disp_data = 0
  - internal shift and BCD registers cleared
  - Rst overrides everything, including a mid-conversion cycle. The partial result is discarded and disp_data reads 0 after reset.
- States: IDLE, SHIFT, FINISH.
- IDLE:
  - start=1 at edge k: capture bin_in into the shift register, clear the BCD accumulator, clear the bit counter, go to SHIFT. busy=1 from edge k.
  - Overflow compare: in the same cycle, the captured value is compared against 10^DIGITS-1 (constant computed at elaboration). The result goes to an internal ovf_pending flag.
  - start=0: remain in IDLE with outputs held.
- SHIFT, one iteration per clock, BIN_W iterations:
  - Every BCD digit >= 5 has 3 added (4-bit add, no carry out).
  - The whole {bcd, shift} vector is then shifted left by 1. The binary MSB enters bcd bit 0.
  - The bit counter increments. When the counter reaches BIN_W-1, go to FINISH on the following edge.
- FINISH, one cycle:
  - disp_data <= ovf_pending ? all-9s : bcd.
  - overflow <= ovf_pending.
  - done = 1 for exactly this cycle.
  - busy drops to 0 on the same edge that raises done. Return to IDLE.
- Latency: start accepted at edge k; disp_data and done are valid after edge k+BIN_W+1. That is 28 cycles at defaults. The next start can be accepted on edge k+BIN_W+2.
- start while busy (SHIFT or FINISH): ignored, and bin_in is not re-sampled. No queuing.
- start held high continuously: back-to-back conversions. A new conversion is accepted in the first IDLE cycle after each done.
- overflow holds its value until the FINISH of the next conversion.
- disp_data changes only in FINISH or on reset.
- bin_in = 0: all iterations run and the result is 0. There is no early termination, so latency is constant.
- Arithmetic: the BCD accumulator is 4*DIGITS bits. Values up to 10^DIGITS-1 never overflow the accumulator. Larger values are caught by the overflow compare, not by the accumulator.

Optional Feature:
- Macro: LEADING_ZERO_MASK_EN.
- When defined:
  - Adds output digit_on [DIGITS-1:0].
  - digit_on is registered in FINISH together with disp_data.
  - Bit i = 1 if digit i is nonzero or any higher digit is nonzero. Bit 0 is always 1.
  - Reset value is 0x01.
  - On overflow, digit_on is all ones.
  - Downstream uses digit_on to gate per-digit select and blank leading zeros.
- When undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset then idle: assert Rst for 2 cycles mid-conversion, started with bin_in=12345678 at cycle 5. Required: busy=0, done=0, disp_data=0x00000000, overflow=0 after reset.
- Normal conversion: start with bin_in=12345678 (0x0BC614E). Required: done pulses exactly 28 cycles after acceptance, disp_data=0x12345678, overflow=0, busy low on the same edge done rises.
- Boundaries:
  - bin_in=0 gives 0x00000000.
  - bin_in=99999999 gives 0x99999999 with overflow=0.
  - bin_in=9 gives 0x00000009. With LEADING_ZERO_MASK_EN, digit_on=0x01.
- Overflow: bin_in=100000000 gives disp_data=0x99999999 and overflow=1. A following conversion of 42 gives 0x00000042 and overflow=0.
- Busy rejection: start at 1234, then pulse start with bin_in=5678 ten cycles later. Required: only one done, disp_data=0x00001234.
- Continuous start: hold start=1 with bin_in toggling between 10 and 20. Required: done every 29 cycles and disp_data alternating 0x00000010 and 0x00000020. Each result matches bin_in as sampled at its acceptance edge.
